// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rvalid, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rvalid, imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit feeding a one-entry IF/ID buffer,
// with redirect support and discard of responses made stale by a redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clock,
   input  logic                reset_n,
   fetch_unit_if.master        imem,
   input  logic                stall,
   input  logic                redirect,
   input  logic [31:0]         redirect_pc,
   output logic                if_valid,
   output logic [31:0]         if_instr,
   output logic [31:0]         if_pc
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

   localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        discard_q, discard_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ifpc_q, ifpc_d;
   logic        run_q;
   logic        blocked;
   logic        accept;
   logic [31:0] target;

   // A full buffer that cannot drain must not trigger another fetch.
   assign blocked = valid_q & stall;
   assign target  = redirect_pc & 32'hFFFF_FFFC;

   // run_q delays the first request until the first edge after reset release.
   assign imem.imem_req  = run_q & (state_q == S_REQ) & ~blocked;
   assign imem.imem_addr = pc_q;
   assign accept         = imem.imem_req & imem.imem_ready;

   assign if_valid = valid_q;
   assign if_instr = instr_q;
   assign if_pc    = ifpc_q;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path can infer a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      discard_d = discard_q;
      valid_d   = valid_q;
      instr_d   = instr_q;
      ifpc_d    = ifpc_q;

      if (valid_q && !stall) valid_d = 1'b0;

      unique case (state_q)
         S_REQ: begin
            if (blocked)     state_d = S_HOLD;
            else if (accept) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem.imem_rvalid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else begin
                  valid_d = 1'b1;
                  instr_d = imem.imem_rdata;
                  ifpc_d  = pc_q;
                  pc_d    = pc_q + 32'd4;
                  state_d = stall ? S_HOLD : S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (!stall) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase

      // A redirect overrides everything; an in-flight response must still be drained.
      if (redirect) begin
         pc_d      = target;
         valid_d   = 1'b0;
         state_d   = S_REQ;
         discard_d = 1'b0;
         if ((state_q == S_WAIT && !imem.imem_rvalid) || (state_q == S_REQ && accept)) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_REQ;
         pc_q      <= PC_INIT;
         discard_q <= 1'b0;
         valid_q   <= 1'b0;
         instr_q   <= 32'h0;
         ifpc_q    <= 32'h0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         ifpc_q    <= ifpc_d;
         run_q     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level memory/buffer model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_unit;

   localparam logic [31:0] MAIN_PC = 32'h0000_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b1;
   logic        stall, redirect;
   logic [31:0] redirect_pc;
   logic        if_valid, if_valid2;
   logic [31:0] if_instr, if_pc, if_instr2, if_pc2;

   fetch_unit_if bus ();
   fetch_unit_if bus2 ();

   fetch_unit #(.RESET_PC(MAIN_PC)) u_dut (
      .clock(clock), .reset_n(reset_n), .imem(bus.master),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
   );

   fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
      .clock(clock), .reset_n(reset_n), .imem(bus2.master),
      .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
      .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
   endfunction

   // ---------------- model: memory responder + IF/ID buffer ----------------
   typedef struct {
      logic [31:0] addr;
      int          cnt;
      bit          killed;
   } txn_t;

   txn_t        pend[$];
   int          lat       = 1;
   bit          stray_req = 1'b0;
   logic        m_valid;
   logic [31:0] m_pc, m_instr, m_next;
   logic        c_req  = 1'b0;
   logic [31:0] c_addr = 32'h0;
   logic        live;
   logic [31:0] live_addr;
   logic [31:0] model_log[$];

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pend.delete();
         m_valid          = 1'b0;
         m_pc             = 32'h0;
         m_instr          = 32'h0;
         m_next           = MAIN_PC & 32'hFFFF_FFFC;
         bus.imem_rvalid  = 1'b0;
         bus.imem_rdata   = 32'h0;
      end else begin
         live      = 1'b0;
         live_addr = 32'h0;
         if (bus.imem_rvalid && pend.size() > 0 && pend[0].cnt == 0) begin
            live      = !pend[0].killed;
            live_addr = pend[0].addr;
            void'(pend.pop_front());
         end
         if (pend.size() > 0 && pend[0].cnt > 0) pend[0].cnt = pend[0].cnt - 1;
         if (redirect) foreach (pend[i]) pend[i].killed = 1'b1;
         if (c_req && bus.imem_ready)
            pend.push_back('{addr: c_addr, cnt: lat - 1, killed: redirect});
         if (live && !redirect) begin
            m_valid = 1'b1;
            m_pc    = live_addr;
            m_instr = instr_of(live_addr);
            m_next  = live_addr + 32'd4;
            model_log.push_back(live_addr);
         end else if (redirect || !stall) begin
            m_valid = 1'b0;
         end
         if (redirect) m_next = redirect_pc & 32'hFFFF_FFFC;
         #1;
         bus.imem_rvalid = (pend.size() > 0 && pend[0].cnt == 0) || stray_req;
         bus.imem_rdata  = (pend.size() > 0 && pend[0].cnt == 0) ? instr_of(pend[0].addr)
                                                                  : 32'hDEAD_BEEF;
         stray_req = 1'b0;
      end
   end

   // Second instance: always-ready memory answering one cycle after each accept.
   logic        c2_req  = 1'b0;
   logic [31:0] c2_addr = 32'h0;
   logic        acc2;
   logic [31:0] a2;

   always @(posedge clock) begin
      acc2 = c2_req && bus2.imem_ready && reset_n;
      a2   = c2_addr;
      #1;
      bus2.imem_rvalid = acc2;
      bus2.imem_rdata  = instr_of(a2);
   end

   // ---------------- compare process ----------------
   int          cyc = 0;
   logic        pv = 1'b0, pv2 = 1'b0;
   logic [31:0] ppc = 32'h0, ppc2 = 32'h0;
   logic [31:0] dut_log[$];
   int          load_cyc[$];
   logic [31:0] log2[$];
   logic [31:0] log2_instr[$];

   always @(negedge clock) begin
      cyc++;
      c_req   = bus.imem_req;
      c_addr  = bus.imem_addr;
      c2_req  = bus2.imem_req;
      c2_addr = bus2.imem_addr;
      if (!reset_n) begin
         check("rst_if_valid", 32'(if_valid), 32'd0);
         check("rst_if_pc", if_pc, 32'h0);
         check("rst_if_instr", if_instr, 32'h0);
         check("rst_imem_req", 32'(bus.imem_req), 32'd0);
      end else begin
         check("if_valid", 32'(if_valid), 32'(m_valid));
         if (m_valid) begin
            check("if_pc", if_pc, m_pc);
            check("if_instr", if_instr, m_instr);
         end
         if (bus.imem_req) begin
            check("req_addr", bus.imem_addr, m_next);
            check("one_outstanding", 32'(pend.size()), 32'd0);
         end
         if (m_valid && stall) check("req_while_full", 32'(bus.imem_req), 32'd0);
         if (if_valid && (!pv || if_pc != ppc)) begin
            dut_log.push_back(if_pc);
            load_cyc.push_back(cyc);
         end
         if (if_valid2 && (!pv2 || if_pc2 != ppc2)) begin
            log2.push_back(if_pc2);
            log2_instr.push_back(if_instr2);
         end
      end
      pv   = if_valid;
      ppc  = if_pc;
      pv2  = if_valid2;
      ppc2 = if_pc2;
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_loads(input int n, input string name);
      int i;
      i = 0;
      while (dut_log.size() < n && i < 60) begin
         tick();
         i++;
      end
      check(name, 32'(dut_log.size() >= n), 32'd1);
   endtask

   task automatic wait_req(input string name);
      int i;
      i = 0;
      while (!bus.imem_req && i < 20) begin
         tick();
         i++;
      end
      check(name, 32'(bus.imem_req), 32'd1);
   endtask

   int n0;
   int waited;

   initial begin
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_pc     = 32'h0;
      bus.imem_ready  = 1'b1;
      bus2.imem_ready = 1'b1;
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;

      // Streaming fetch from reset, one instruction every two cycles.
      wait_loads(4, "a_loads");
      for (int k = 0; k < 4; k++) begin
         check($sformatf("a_dut_pc%0d", k), dut_log[k], 32'(4 * k));
         check($sformatf("a_model_pc%0d", k), model_log[k], 32'(4 * k));
      end
      for (int k = 0; k < 3; k++)
         check($sformatf("a_spacing%0d", k), 32'(load_cyc[k + 1] - load_cyc[k]), 32'd2);
      check("wrap_pc0", log2[0], 32'hFFFF_FFF8);
      check("wrap_pc1", log2[1], 32'hFFFF_FFFC);
      check("wrap_pc2", log2[2], 32'h0000_0000);
      check("wrap_instr2", log2_instr[2], instr_of(32'h0));

      // Stall held for three cycles on a live instruction.
      waited = 0;
      while (!if_valid && waited < 10) begin
         tick();
         waited++;
      end
      check("b_valid_seen", 32'(if_valid), 32'd1);
      stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("b_hold_valid", 32'(if_valid), 32'd1);
         check("b_hold_pc", if_pc, 32'h0000_0010);
         check("b_hold_instr", if_instr, instr_of(32'h0000_0010));
         check("b_hold_req", 32'(bus.imem_req), 32'd0);
         tick();
      end
      stall = 1'b0;
      tick();
      check("b_release_req", 32'(bus.imem_req), 32'd1);
      check("b_release_addr", bus.imem_addr, 32'h0000_0014);
      check("b_release_valid", 32'(if_valid), 32'd0);

      // Redirect while waiting: the in-flight response must be dropped.
      lat = 3;
      wait_req("c_req_seen");
      tick();
      check("c_in_wait", 32'(bus.imem_req), 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      waited   = 0;
      while (!bus.imem_req && waited < 10) begin
         check("c_no_valid", 32'(if_valid), 32'd0);
         tick();
         waited++;
      end
      check("c_wait_cycles", 32'(waited), 32'd2);
      check("c_addr", bus.imem_addr, 32'h0000_0100);
      check("c_model_next", m_next, 32'h0000_0100);

      // Redirect on the same edge as a response.
      lat = 1;
      wait_req("d_req_seen");
      tick();
      check("d_rvalid_now", 32'(bus.imem_rvalid), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      check("d_valid", 32'(if_valid), 32'd0);
      check("d_req", 32'(bus.imem_req), 32'd1);
      check("d_addr", bus.imem_addr, 32'h0000_0200);
      n0 = dut_log.size();
      wait_loads(n0 + 1, "d_load");
      check("d_first_pc", dut_log[n0], 32'h0000_0200);

      // Redirect in REQ without ready retargets the pending request.
      bus.imem_ready = 1'b0;
      wait_req("e_req_seen");
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0304;
      tick();
      redirect = 1'b0;
      check("e_retarget_req", 32'(bus.imem_req), 32'd1);
      check("e_retarget_addr", bus.imem_addr, 32'h0000_0304);
      bus.imem_ready = 1'b1;

      // Reset while waiting; a late response after release must be ignored.
      lat = 3;
      tick();
      check("f_in_wait", 32'(bus.imem_req), 32'd0);
      reset_n = 1'b0;
      tick();
      reset_n        = 1'b1;
      bus.imem_ready = 1'b0;
      stray_req      = 1'b1;
      #1;
      check("f_req_before_edge", 32'(bus.imem_req), 32'd0);
      tick();
      check("f_stray_rvalid", 32'(bus.imem_rvalid), 32'd1);
      check("f_req_after_edge", 32'(bus.imem_req), 32'd1);
      check("f_restart_addr", bus.imem_addr, 32'h0000_0000);
      check("f_valid", 32'(if_valid), 32'd0);
      bus.imem_ready = 1'b1;
      n0 = dut_log.size();
      wait_loads(n0 + 1, "f_load");
      check("f_first_pc", dut_log[n0], 32'h0000_0000);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, shall set the first fetch address after reset (bits [1:0] SHALL be treated as 0).
REQ-002 clock  input  1  shall be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  shall be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  shall signal that a fetch request is valid.
REQ-005 imem_addr  output  32  shall carry the word-aligned fetch address.
REQ-006 imem_ready  input  1  shall signal that memory accepts the request this cycle.
REQ-007 imem_rvalid  input  1  shall signal that imem_rdata holds the response.
REQ-008 imem_rdata  input  32  shall carry the fetched instruction word.
REQ-009 stall  input  1  shall signal that the IF/ID register cannot accept a new instruction.
REQ-010 redirect  input  1  shall request a fetch-stream change (branch/jump).
REQ-011 redirect_pc  input  32  shall carry the redirect target.
REQ-012 if_valid  output  1  shall signal that if_instr/if_pc hold a live instruction for IF/ID.
REQ-013 if_instr  output  32  shall carry the instruction word to IF/ID.
REQ-014 if_pc  output  32  shall carry the address of if_instr (IF/ID adds 4 itself).

Function
REQ-015 The block SHALL keep at most one memory request outstanding.
REQ-016 The block SHALL use states REQ, WAIT, HOLD; HOLD means the output buffer is full and stalled.
REQ-017 REQ: imem_req=1, imem_addr=pc; on imem_ready=1 the block SHALL go to WAIT; otherwise it SHALL stay in REQ with imem_addr held stable.
REQ-018 WAIT: imem_req=0; on imem_rvalid=1 with no pending discard, the block SHALL load the output buffer (if_instr<=imem_rdata, if_pc<=pc, if_valid<=1) and set pc<=pc+4.
REQ-019 After the load, the block SHALL go to REQ if stall=0, else HOLD.
REQ-020 HOLD: imem_req=0, outputs held; when stall=0 the block SHALL go to REQ.
REQ-021 if_valid SHALL fall to 0 on the edge where stall=0 and no new load occurs (instruction consumed).
REQ-022 A response and a consume on the same edge SHALL load the new instruction with if_valid staying 1, with no bubble.
REQ-023 Latency: the minimum time from imem_req/imem_ready accept to if_valid is one cycle after imem_rvalid, which may itself arrive one cycle after the accept at the earliest.
REQ-024 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-025 redirect=1 SHALL have priority over stall and over any response in the same cycle: pc<=redirect_pc with [1:0] forced to 0, if_valid<=0, next state REQ.
REQ-026 If redirect occurs in WAIT (request accepted, no response yet), the block SHALL set a discard flag, stay in WAIT, drop the next imem_rvalid response, clear the flag, and then go to REQ.
REQ-027 If redirect coincides with imem_rvalid in WAIT, that response SHALL be dropped and no discard flag set.
REQ-028 If redirect occurs in REQ without imem_ready, the request SHALL be retargeted next cycle; if it occurs with imem_ready, REQ-026 SHALL apply.
REQ-029 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-030 While reset_n=0: pc=RESET_PC, state=REQ, if_valid=0, if_instr=0, if_pc=0, imem_req=0, discard flag=0.
REQ-031 imem_req SHALL assert on the first rising edge after reset_n deasserts, and a reset mid-transaction SHALL abandon the outstanding response.

Verification
REQ-032 Reset, imem_ready=1, rvalid one cycle after each accept, stall=0 -> if_pc sequence 0,4,8,C with if_instr matching imem_rdata and one valid per two cycles.
REQ-033 stall=1 held 3 cycles while if_valid=1 -> if_instr/if_pc unchanged, imem_req=0; on release, imem_req=1 next cycle with addr = held if_pc+4.
REQ-034 redirect to 32'h0000_0103 while in WAIT -> next rvalid dropped (if_valid stays 0), then imem_addr=32'h0000_0100.
REQ-035 redirect with imem_rvalid on the same edge -> response dropped, imem_addr=redirect target the next cycle.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 reset_n low while in WAIT, then rvalid arrives after release -> response ignored, fetch restarts at RESET_PC.
